// File: rtl/phys_reg_freelist.sv
// ---------------------------------------------------------------------------
// phys_reg_freelist
//   Physical-register free list for the rename path. A bitmap of available
//   physical registers (PRs) is held in avail_q. Up to N_WAY tags are granted
//   combinationally each cycle in lane order (lane 0 oldest). Retire returns
//   PRs through free_mask_i. On a mispredict the whole bitmap is replaced by
//   restore_mask_i. PR0 is never available.
//
// Ports
//   clock_i        : clock, rising edge
//   reset_i        : asynchronous reset, active low
//   alloc_req_i    : per-lane allocation request
//   alloc_valid_o  : per-lane grant
//   alloc_tags_o   : per-lane granted tag (0 when not granted)
//   free_count_o   : registered popcount of the available bitmap
//   free_mask_i    : PRs released by retire this cycle (bit 0 ignored)
//   mispredict_i   : adopt restore_mask_i, suppress grants this cycle
//   restore_mask_i : complete available bitmap to adopt on mispredict
//   double_free_o  : sticky flag, a free hit an already-available PR
// ---------------------------------------------------------------------------

// One allocation lane: picks the lowest set bit of the mask it is offered.
module phys_reg_freelist_lane #(
    parameter int NUM_PR = 64,
    parameter int PRW    = 6
) (
    input  logic              req_i,
    input  logic [NUM_PR-1:0] avail_i,
    output logic              vld_o,
    output logic [PRW-1:0]    tag_o,
    output logic [NUM_PR-1:0] take_o
);
    always_comb begin
        vld_o  = 1'b0;
        tag_o  = '0;
        take_o = '0;
        if (req_i) begin
            // Descending scan: the last hit written is the lowest index.
            for (int i = NUM_PR - 1; i >= 0; i--) begin
                if (avail_i[i]) begin
                    vld_o = 1'b1;
                    tag_o = PRW'(i);
                end
            end
            if (vld_o) take_o[tag_o] = 1'b1;
        end
    end
endmodule

module phys_reg_freelist #(
    parameter int N_WAY    = 3,
    parameter int NUM_PR   = 64,
    parameter int NUM_ARCH = 32
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [N_WAY-1:0]                  alloc_req_i,
    output logic [N_WAY-1:0]                  alloc_valid_o,
    output logic [N_WAY-1:0][$clog2(NUM_PR)-1:0] alloc_tags_o,
    output logic [$clog2(NUM_PR+1)-1:0]       free_count_o,
    input  logic [NUM_PR-1:0]                 free_mask_i,
    input  logic                              mispredict_i,
    input  logic [NUM_PR-1:0]                 restore_mask_i,
    output logic                              double_free_o
);
    localparam int PRW = $clog2(NUM_PR);
    localparam int CW  = $clog2(NUM_PR + 1);

    // Architectural registers start mapped, so only the upper PRs are free.
    localparam logic [NUM_PR-1:0] RST_AVAIL =
        {{(NUM_PR - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
    localparam logic [CW-1:0]     RST_CNT   = CW'(NUM_PR - NUM_ARCH);
    // Clears PR0 on every path into avail_q.
    localparam logic [NUM_PR-1:0] NZ_MASK   = {{(NUM_PR - 1){1'b1}}, 1'b0};

    logic [NUM_PR-1:0] avail_q, avail_d;
    logic [CW-1:0]     free_count_q, free_count_d;
    logic              double_free_q, double_free_d;

    // rem[g] is what is still grantable when lane g looks at the bitmap.
    // A mispredict offers nothing, which forces every grant low.
    logic [N_WAY:0][NUM_PR-1:0]   rem;
    logic [N_WAY-1:0][NUM_PR-1:0] take;
    logic [NUM_PR-1:0]            granted;

    assign rem[0] = mispredict_i ? '0 : avail_q;

    for (genvar g = 0; g < N_WAY; g++) begin : g_lane
        phys_reg_freelist_lane #(
            .NUM_PR (NUM_PR),
            .PRW    (PRW)
        ) u_lane (
            .req_i   (alloc_req_i[g]),
            .avail_i (rem[g]),
            .vld_o   (alloc_valid_o[g]),
            .tag_o   (alloc_tags_o[g]),
            .take_o  (take[g])
        );
        assign rem[g+1] = rem[g] & ~take[g];
    end

    assign granted = rem[0] & ~rem[N_WAY];

    function automatic logic [CW-1:0] popcnt(input logic [NUM_PR-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_PR; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    always_comb begin
        avail_d       = avail_q;
        double_free_d = double_free_q;
        if (mispredict_i) begin
            // restore_mask already reflects this cycle's frees.
            avail_d = restore_mask_i & NZ_MASK;
        end else begin
            avail_d       = ((avail_q & ~granted) | free_mask_i) & NZ_MASK;
            double_free_d = double_free_q |
                            (|(free_mask_i & avail_q & NZ_MASK));
        end
        free_count_d = popcnt(avail_d);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            avail_q       <= RST_AVAIL & NZ_MASK;
            free_count_q  <= RST_CNT;
            double_free_q <= 1'b0;
        end else begin
            avail_q       <= avail_d;
            free_count_q  <= free_count_d;
            double_free_q <= double_free_d;
        end
    end

    assign free_count_o  = free_count_q;
    assign double_free_o = double_free_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_freelist
//   Directed stimulus for the physical-register free list. A bitmap model of
//   the free list is checked against the DUT on every falling edge; literal
//   expectations along the directed sequence pin the model itself.
// ---------------------------------------------------------------------------
module tb_phys_reg_freelist;
    localparam int N   = 3;
    localparam int NPR = 64;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0]        alloc_req = '0;
    logic [N-1:0]        alloc_valid;
    logic [N-1:0][5:0]   alloc_tags;
    logic [6:0]          free_count;
    logic [NPR-1:0]      free_mask = '0;
    logic                mispredict = 1'b0;
    logic [NPR-1:0]      restore_mask = '0;
    logic                double_free;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    phys_reg_freelist #(.N_WAY(N), .NUM_PR(NPR), .NUM_ARCH(32)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .alloc_req_i    (alloc_req),
        .alloc_valid_o  (alloc_valid),
        .alloc_tags_o   (alloc_tags),
        .free_count_o   (free_count),
        .free_mask_i    (free_mask),
        .mispredict_i   (mispredict),
        .restore_mask_i (restore_mask),
        .double_free_o  (double_free)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model: free list as a set of PR numbers ----------------
    bit [NPR-1:0] m_free;   // m_free[p] = PR p is on the free list
    bit           m_df;

    // Each requesting lane, oldest first, takes the smallest free PR left.
    function automatic void model_alloc(input bit [NPR-1:0] fl, input logic [N-1:0] req,
                                        input logic mis, output logic [N-1:0] v,
                                        output logic [N-1:0][5:0] t,
                                        output bit [NPR-1:0] taken);
        bit found;
        v = '0; t = '0; taken = '0;
        if (!mis) begin
            for (int l = 0; l < N; l++) begin
                found = 1'b0;
                if (req[l]) begin
                    for (int p = 1; p < NPR; p++) begin
                        if (!found && fl[p] && !taken[p]) begin
                            found    = 1'b1;
                            v[l]     = 1'b1;
                            t[l]     = 6'(p);
                            taken[p] = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [N-1:0]      v;
        logic [N-1:0][5:0] t;
        bit   [NPR-1:0]    taken;
        if (!reset) begin
            m_free = '0;
            for (int p = 32; p < NPR; p++) m_free[p] = 1'b1;
            m_df = 1'b0;
        end else begin
            model_alloc(m_free, alloc_req, mispredict, v, t, taken);
            if (mispredict) begin
                m_free = restore_mask;
            end else begin
                for (int p = 1; p < NPR; p++)
                    if (free_mask[p] && m_free[p]) m_df = 1'b1;
                m_free = (m_free & ~taken) | free_mask;
            end
            m_free[0] = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [N-1:0]      ev;
        logic [N-1:0][5:0] et;
        bit   [NPR-1:0]    taken;
        if (chk_en) begin
            model_alloc(m_free, alloc_req, mispredict, ev, et, taken);
            chk("valid", 64'(alloc_valid), 64'(ev));
            for (int l = 0; l < N; l++) chk("tag", 64'(alloc_tags[l]), 64'(et[l]));
            chk("free_count", 64'(free_count), 64'($countones(m_free)));
            chk("double_free", 64'(double_free), 64'(m_df));
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic [N-1:0] req, input logic [NPR-1:0] fm,
                         input logic mis, input logic [NPR-1:0] rm);
        @(posedge clock);
        #1;
        alloc_req    = req;
        free_mask    = fm;
        mispredict   = mis;
        restore_mask = rm;
        @(negedge clock);
    endtask

    initial begin
        @(posedge clock);
        #1 chk_en = 1'b1;
        @(negedge clock);
        chk("rst_count", 64'(free_count), 64'd32);
        chk("rst_valid", 64'(alloc_valid), 64'd0);

        // Release reset together with a full-width request.
        @(posedge clock);
        #1 reset = 1'b1;
        alloc_req = 3'b111;
        @(negedge clock);
        chk("a111_valid", 64'(alloc_valid), 64'b111);
        chk("a111_tag0", 64'(alloc_tags[0]), 64'd32);
        chk("a111_tag1", 64'(alloc_tags[1]), 64'd33);
        chk("a111_tag2", 64'(alloc_tags[2]), 64'd34);

        drive(3'b101, '0, 1'b0, '0);
        chk("cnt29", 64'(free_count), 64'd29);
        chk("a101_valid", 64'(alloc_valid), 64'b101);
        chk("a101_tag0", 64'(alloc_tags[0]), 64'd35);
        chk("a101_tag1", 64'(alloc_tags[1]), 64'd0);
        chk("a101_tag2", 64'(alloc_tags[2]), 64'd36);

        drive(3'b000, '0, 1'b0, '0);
        chk("cnt27", 64'(free_count), 64'd27);

        // Drain 37..62, leaving only PR63.
        repeat (8) drive(3'b111, '0, 1'b0, '0);
        repeat (2) drive(3'b001, '0, 1'b0, '0);
        drive(3'b111, '0, 1'b0, '0);
        chk("last_cnt", 64'(free_count), 64'd1);
        chk("last_valid", 64'(alloc_valid), 64'b001);
        chk("last_tag", 64'(alloc_tags[0]), 64'd63);

        drive(3'b111, '0, 1'b0, '0);
        chk("empty_cnt", 64'(free_count), 64'd0);
        chk("empty_valid", 64'(alloc_valid), 64'b000);

        // Free PR5 (and PR0, which must be ignored); no same-cycle bypass.
        drive(3'b001, 64'h21, 1'b0, '0);
        chk("nobypass_valid", 64'(alloc_valid), 64'b000);
        drive(3'b001, '0, 1'b0, '0);
        chk("pr5_cnt", 64'(free_count), 64'd1);
        chk("pr5_valid", 64'(alloc_valid), 64'b001);
        chk("pr5_tag", 64'(alloc_tags[0]), 64'd5);
        chk("pr0_nodf", 64'(double_free), 64'd0);

        // Mispredict: grants suppressed, bitmap replaced, PR0 forced clear.
        drive(3'b111, '0, 1'b1, 64'hFFFFFF00_00000001);
        chk("mis_cnt_before", 64'(free_count), 64'd0);
        chk("mis_valid", 64'(alloc_valid), 64'b000);
        drive(3'b000, '0, 1'b0, '0);
        chk("mis_cnt", 64'(free_count), 64'd24);

        // Free PR50 while it is already available.
        drive(3'b000, 64'(1) << 50, 1'b0, '0);
        chk("df_not_yet", 64'(double_free), 64'd0);
        for (int i = 0; i < 10; i++) begin
            drive(3'b000, '0, 1'b0, '0);
            chk("df_sticky", 64'(double_free), 64'd1);
            chk("df_cnt", 64'(free_count), 64'd24);
        end

        // Reset in the middle of a cycle takes effect without a clock edge.
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_df", 64'(double_free), 64'd0);
        chk("async_cnt", 64'(free_count), 64'd32);
        @(posedge clock);
        #1 reset = 1'b1;

        // A few mixed cycles checked by the model alone.
        drive(3'b011, (64'(1) << 2) | (64'(1) << 7), 1'b0, '0);
        drive(3'b110, 64'(1) << 33, 1'b0, '0);
        drive(3'b111, '0, 1'b0, '0);
        drive(3'b010, 64'(1) << 35, 1'b0, '0);
        drive(3'b000, '0, 1'b0, '0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phys_reg_freelist.md
Name: phys_reg_freelist

Overview:
- Physical-register free list for the R10K-style rename path.
- Holds a bitmap of available physical registers.
- Grants up to N tags per cycle to dispatch, in lane order.
- Reclaims registers from the retire stage's per-cycle free bitmap, and on a retire-detected mispredict replaces the whole bitmap with the retire-supplied restore mask.
- Sits between retire (producer of frees/restore) and dispatch/rename (consumer of tags).

Parameters:
- N_WAY, `N (3), superscalar width / number of allocation lanes.
- NUM_PR, `PHYS_REG_SZ_R10K (64), number of physical registers.
- NUM_ARCH, `ARCH_REG_SZ (32), number of architectural registers initially mapped.
- PRW, $clog2(NUM_PR), tag width (derived, not overridable).

Ports:
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low (0 = reset asserted).
- alloc_req, in, N_WAY, per-lane request; lane 0 oldest.
- alloc_valid, out, N_WAY, per-lane grant.
- alloc_tags, out, N_WAY x PRW, granted tag per lane; 0 when not granted.
- free_count, out, $clog2(NUM_PR+1), registered popcount of available bitmap.
- free_mask, in, NUM_PR, PRs released by retire this cycle.
- mispredict, in, 1, retire-detected mispredict this cycle.
- restore_mask, in, NUM_PR, complete available bitmap to adopt on mispredict.
- double_free, out, 1, sticky error flag.

Behaviour:
- State:
  - avail[NUM_PR-1:0] register.
  - free_count register.
  - double_free register.
- Reset (async, reset==0):
  - avail = bits [NUM_ARCH-1:0] cleared, rest set.
  - free_count = NUM_PR-NUM_ARCH (32).
  - double_free = 0.
  - Outputs combinational from state: with alloc_req=0, alloc_valid=0 and alloc_tags=0.
  - Reset mid-operation discards all pending state immediately.
- Bit 0 (PR0) is never available.
  - avail[0] is forced 0 in every next-state path, including restore.
  - free_mask[0] is ignored.
- Allocation (combinational, same cycle; zero latency):
  - Walk lanes 0..N_WAY-1.
  - Each lane with alloc_req=1 takes the lowest-indexed set bit of avail not already taken by an older lane.
  - Lanes without a request take nothing; gaps in alloc_req are allowed.
  - When bits run out, that lane and all younger requesting lanes get alloc_valid=0 and tag 0.
  - Partial grants are legal; dispatch stalls the ungranted lanes.
  - Allocation sees only the registered avail. PRs in this cycle's free_mask are not grantable until the next cycle (no bypass).
- Normal next state (mispredict=0):
  - avail_next = (avail & ~granted) | (free_mask with bit0 cleared).
  - free_count_next = popcount(avail_next).
- Mispredict (mispredict=1):
  - alloc_valid forced to all 0 and alloc_tags to 0 that cycle.
  - free_mask is ignored, because restore_mask already includes this cycle's frees.
  - avail_next = restore_mask with bit0 cleared.
  - free_count_next = popcount of that value.
- double_free:
  - Set next cycle when any free_mask[i] (i≠0) is 1 while avail[i] is already 1 and mispredict=0.
  - Sticky until reset.
  - Detection only; avail behaviour is unchanged (OR semantics).
- free_count always equals popcount(avail) after each edge. Range 0..NUM_PR-1.
- Empty list (avail=0): all requests denied; frees make PRs available on the following cycle.
- Full list (all non-zero PRs available) plus an extra free of an already-available PR: this is a double free and sets the flag.

Test Plan:
- Release reset; alloc_req=3'b111 -> alloc_valid=111, tags 32/33/34. Next cycle free_count=29, avail[34:32]=0.
- From that state, alloc_req=3'b101 -> lane0 tag 35, lane1 valid 0 tag 0, lane2 tag 36. Next cycle free_count=27.
- Drain until free_count=1 (only PR63 left); alloc_req=111 -> alloc_valid=001, tag 63. Next cycle free_count=0; alloc_req=111 -> valid 000.
- With free_count=0: free_mask bit 5 and alloc_req=001 in the same cycle -> valid 0. Next cycle alloc_req=001 -> tag 5 granted, free_count 1→0.
- Mid-stream: mispredict=1, restore_mask = bits 40..63 set plus bit 0 set, alloc_req=111 -> alloc_valid=000. Next cycle avail = bits 40..63 only (bit 0 forced clear), free_count=24.
- Double free and reset:
  - free_mask bit 50 while avail[50]=1 -> double_free=1 next cycle, held for 10 cycles.
  - Drive reset=0 mid-cycle -> double_free=0 and free_count=32 immediately, without waiting for a clock edge.
